// File: rtl/posit_encode_4_0_if.sv
// Stream bundle between the posit datapath and the encoder: denormalized
// input beat with valid/ready, and the packed posit result with valid/ready.
interface posit_encode_4_0_if #(
    parameter int N       = 4,
    parameter int FRAC_W  = 4,
    parameter int SCALE_W = 4
);
    logic               valid_i;
    logic               ready_o;
    logic [FRAC_W-1:0]  fraction_i;
    logic [SCALE_W-1:0] scale_i;
    logic               NaR_i;
    logic               zero_i;
    logic               sign_i;
    logic               valid_o;
    logic               ready_i;
    logic [N-1:0]       posit_o;

    modport slave (
        input  valid_i, fraction_i, scale_i, NaR_i, zero_i, sign_i, ready_i,
        output ready_o, valid_o, posit_o
    );

    modport master (
        output valid_i, fraction_i, scale_i, NaR_i, zero_i, sign_i, ready_i,
        input  ready_o, valid_o, posit_o
    );
endinterface

// File: rtl/posit_encode_4_0.sv
// Posit<N,ES> encoder: packs sign/scale/fraction into posit bits with
// round-to-nearest-even and saturation, in a 2-stage valid/ready pipeline.
module posit_encode_4_0 #(
    parameter int N       = 4,
    parameter int ES      = 0,
    parameter int FRAC_W  = 4,
    parameter int SCALE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    posit_encode_4_0_if.slave  bus
);
    localparam int TAIL_W = ES + FRAC_W;
    // Body (terminator + exponent + fraction) plus room for the longest unclamped regime shift
    localparam int FW = 1 + TAIL_W + N - 2;
    localparam logic [FW-1:0] ALL_ONES = '1;

    // ---------------- stage 1 combinational: regime/exponent/fraction layout
    logic [TAIL_W-1:0]        tail;
    logic signed [SCALE_W-1:0] k;
    int                        k_int;
    logic [FW-1:0]             body_pos;
    logic [FW-1:0]             body_neg;
    logic [FW-1:0]             field;
    logic [N-2:0]              main_next;
    logic                      guard_next;
    logic                      sticky_next;
    logic                      max_next;
    logic                      min_next;

    generate
        if (ES == 0) begin : g_no_exp
            assign tail = bus.fraction_i;
        end else begin : g_exp
            assign tail = {bus.scale_i[ES-1:0], bus.fraction_i};
        end
    endgenerate

    assign k        = $signed(bus.scale_i) >>> ES;
    assign k_int    = int'(k);
    assign body_pos = {1'b0, tail, {(N-2){1'b0}}};
    assign body_neg = {1'b1, tail, {(N-2){1'b0}}};

    always_comb begin
        field = '0;
        if (k_int >= 0) begin
            // (k+1) ones, then the 0 terminator at the head of body_pos
            field = (body_pos >> (k_int + 1)) | ~(ALL_ONES >> (k_int + 1));
        end else begin
            // (-k) zeros, then the 1 terminator at the head of body_neg
            field = body_neg >> (-k_int);
        end
    end

    assign main_next   = field[FW-1 -: N-1];
    assign guard_next  = field[FW-N];
    assign sticky_next = |field[FW-N-1:0];
    assign max_next    = (k_int >= N - 2);
    assign min_next    = (k_int < -(N - 2));

    // ---------------- stage 1 registers
    logic         s1_valid_reg;
    logic [N-2:0] s1_main_reg;
    logic         s1_guard_reg;
    logic         s1_sticky_reg;
    logic         s1_max_reg;
    logic         s1_min_reg;
    logic         s1_nar_reg;
    logic         s1_zero_reg;
    logic         s1_sign_reg;

    logic s2_valid_reg;
    logic s2_load;
    logic s1_load;

    assign s2_load     = !s2_valid_reg || bus.ready_i;
    assign bus.ready_o = !s1_valid_reg || !s2_valid_reg || bus.ready_i;
    assign s1_load     = bus.ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_main_reg   <= '0;
            s1_guard_reg  <= 1'b0;
            s1_sticky_reg <= 1'b0;
            s1_max_reg    <= 1'b0;
            s1_min_reg    <= 1'b0;
            s1_nar_reg    <= 1'b0;
            s1_zero_reg   <= 1'b0;
            s1_sign_reg   <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= bus.valid_i;
            if (bus.valid_i) begin
                s1_main_reg   <= main_next;
                s1_guard_reg  <= guard_next;
                s1_sticky_reg <= sticky_next;
                s1_max_reg    <= max_next;
                s1_min_reg    <= min_next;
                s1_nar_reg    <= bus.NaR_i;
                s1_zero_reg   <= bus.zero_i;
                s1_sign_reg   <= bus.sign_i;
            end
        end
    end

    // ---------------- stage 2 combinational: RNE, saturation, sign, specials
    logic         round_up;
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic [N-1:0] enc;
    logic [N-1:0] posit_next;

    assign round_up = s1_guard_reg && (s1_sticky_reg || s1_main_reg[0]);
    assign sum      = {1'b0, s1_main_reg} + {{(N-1){1'b0}}, round_up};

    always_comb begin
        mag = sum[N-2:0];
        // A carry out of the field or the explicit clamp both land on maxpos
        if (s1_max_reg || sum[N-1]) begin
            mag = '1;
        end else if (s1_min_reg || (sum == '0)) begin
            mag = {{(N-2){1'b0}}, 1'b1};
        end
        enc = {1'b0, mag};
        if (s1_sign_reg) begin
            enc = ~enc + {{(N-1){1'b0}}, 1'b1};
        end
        posit_next = enc;
        if (s1_nar_reg) begin
            posit_next = {1'b1, {(N-1){1'b0}}};
        end else if (s1_zero_reg) begin
            posit_next = '0;
        end
    end

    // ---------------- stage 2 registers (output)
    logic [N-1:0] posit_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            posit_reg    <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                posit_reg <= posit_next;
            end
        end
    end

    assign bus.valid_o = s2_valid_reg;
    assign bus.posit_o = posit_reg;
endmodule

// File: tb/tb_posit_encode_4_0.sv
// Directed bench for posit_encode_4_0: hand-computed posit<4,0> vectors,
// backpressure stall, and asynchronous reset with beats in flight.
module tb_posit_encode_4_0;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    posit_encode_4_0_if #(.N(4), .FRAC_W(4), .SCALE_W(4)) bus ();

    posit_encode_4_0 #(.N(4), .ES(0), .FRAC_W(4), .SCALE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [3:0] s,
                         input logic nar, input logic zero, input logic sign);
        bus.fraction_i = f;
        bus.scale_i    = s;
        bus.NaR_i      = nar;
        bus.zero_i     = zero;
        bus.sign_i     = sign;
    endtask

    task automatic send_one(input string tag, input logic [3:0] f, input logic [3:0] s,
                            input logic nar, input logic zero, input logic sign,
                            input logic [3:0] exp);
        @(negedge clk);
        drive(f, s, nar, zero, sign);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        check({tag, "_lat1"}, 32'(bus.valid_o), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check(tag, 32'(bus.posit_o), 32'(exp));
        $display("%s: frac=%b scale=%0d nar=%b zero=%b sign=%b -> posit_o=%b (exp %b)",
                 tag, f, $signed(s), nar, zero, sign, bus.posit_o, exp);
    endtask

    logic [3:0] t_frac  [8];
    logic [3:0] t_scale [8];
    logic       t_sign  [8];
    logic [3:0] t_exp   [8];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

        t_frac[0] = 4'h0; t_scale[0] = 4'h0; t_sign[0] = 1'b0; t_exp[0] = 4'b0100;
        t_frac[1] = 4'hC; t_scale[1] = 4'h0; t_sign[1] = 1'b0; t_exp[1] = 4'b0110;
        t_frac[2] = 4'h2; t_scale[2] = 4'h1; t_sign[2] = 1'b0; t_exp[2] = 4'b0110;
        t_frac[3] = 4'h8; t_scale[3] = 4'hF; t_sign[3] = 1'b1; t_exp[3] = 4'b1101;
        t_frac[4] = 4'h0; t_scale[4] = 4'h3; t_sign[4] = 1'b0; t_exp[4] = 4'b0111;
        t_frac[5] = 4'h0; t_scale[5] = 4'hC; t_sign[5] = 1'b0; t_exp[5] = 4'b0001;
        t_frac[6] = 4'h6; t_scale[6] = 4'h0; t_sign[6] = 1'b0; t_exp[6] = 4'b0101;
        t_frac[7] = 4'h8; t_scale[7] = 4'h1; t_sign[7] = 1'b1; t_exp[7] = 4'b1010;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid_o", 32'(bus.valid_o), 32'd0);
        check("rst_posit_o", 32'(bus.posit_o), 32'd0);
        check("rst_ready_o", 32'(bus.ready_o), 32'd1);
        rst = 1'b0;

        // T1/T2: nominal values and round-to-nearest-even
        send_one("t1_one",       4'h0, 4'h0, 0, 0, 0, 4'b0100);
        send_one("t2_tie_even",  4'hC, 4'h0, 0, 0, 0, 4'b0110);
        send_one("t2_2p25",      4'h2, 4'h1, 0, 0, 0, 4'b0110);
        send_one("t2_neg_0p75",  4'h8, 4'hF, 0, 0, 1, 4'b1101);
        send_one("rne_1p25_tie", 4'h4, 4'h0, 0, 0, 0, 4'b0100);
        send_one("rne_1p375_up", 4'h6, 4'h0, 0, 0, 0, 4'b0101);
        send_one("rne_3_tie",    4'h8, 4'h1, 0, 0, 0, 4'b0110);
        send_one("rne_carry_max",4'h9, 4'h1, 0, 0, 0, 4'b0111);
        send_one("rne_minpos_up",4'h8, 4'hE, 0, 0, 0, 4'b0010);
        send_one("k_m2_exact",   4'h0, 4'hE, 0, 0, 0, 4'b0001);
        send_one("k_m2_below",   4'h4, 4'hE, 0, 0, 0, 4'b0001);
        // T3: saturation, never to zero
        send_one("t3_maxpos",    4'h0, 4'h3, 0, 0, 0, 4'b0111);
        send_one("t3_minpos",    4'h0, 4'hC, 0, 0, 0, 4'b0001);
        send_one("t3_neg_max",   4'h0, 4'h3, 0, 0, 1, 4'b1001);
        send_one("t3_neg_min",   4'h0, 4'hC, 0, 0, 1, 4'b1111);
        send_one("sat_k2",       4'h0, 4'h2, 0, 0, 0, 4'b0111);
        send_one("sat_s7",       4'hF, 4'h7, 0, 0, 0, 4'b0111);
        send_one("sat_s_m8",     4'hF, 4'h8, 0, 0, 0, 4'b0001);
        send_one("sat_s_m3",     4'hF, 4'hD, 0, 0, 0, 4'b0001);
        // T4: specials
        send_one("t4_nar_zero",  4'h5, 4'h1, 1, 1, 0, 4'b1000);
        send_one("t4_zero_neg",  4'h5, 4'h1, 0, 1, 1, 4'b0000);
        send_one("nar_neg",      4'h0, 4'h3, 1, 0, 1, 4'b1000);

        // T5: 8 back-to-back beats, downstream stalls cycles 3..7
        begin
            int in_idx;
            int out_idx;
            in_idx  = 0;
            out_idx = 0;
            @(posedge clk);
            for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
                @(negedge clk);
                bus.ready_i = !(cyc >= 3 && cyc <= 7);
                if (in_idx < 8) begin
                    drive(t_frac[in_idx], t_scale[in_idx], 1'b0, 1'b0, t_sign[in_idx]);
                    bus.valid_i = 1'b1;
                end else begin
                    bus.valid_i = 1'b0;
                end
                #1;
                if (cyc >= 3 && cyc <= 7) begin
                    check("t5_ready_low", 32'(bus.ready_o), 32'd0);
                    check("t5_hold_valid", 32'(bus.valid_o), 32'd1);
                    check("t5_hold_data", 32'(bus.posit_o), 32'(t_exp[out_idx]));
                end
                if (bus.valid_o && bus.ready_i) begin
                    check($sformatf("t5_out%0d", out_idx), 32'(bus.posit_o), 32'(t_exp[out_idx]));
                    $display("t5 beat %0d: posit_o=%b (exp %b) cycle %0d",
                             out_idx, bus.posit_o, t_exp[out_idx], cyc);
                    out_idx++;
                end
                if (bus.valid_i && bus.ready_o) in_idx++;
            end
            check("t5_in_count", 32'(in_idx), 32'd8);
            check("t5_out_count", 32'(out_idx), 32'd8);
            bus.valid_i = 1'b0;
            bus.ready_i = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                check("t5_no_extra", 32'(bus.valid_o), 32'd0);
            end
        end

        // T6: async reset with two beats in flight
        @(negedge clk);
        drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        drive(4'hC, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        #1;
        check("t6_pre_valid", 32'(bus.valid_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(bus.valid_o), 32'd0);
        check("t6_rst_posit", 32'(bus.posit_o), 32'd0);
        check("t6_rst_ready", 32'(bus.ready_o), 32'd1);
        $display("t6: reset asserted mid-cycle, valid_o=%b posit_o=%b", bus.valid_o, bus.posit_o);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t6_no_stale", 32'(bus.valid_o), 32'd0);
        end
        send_one("t6_after", 4'hC, 4'h1, 0, 0, 0, 4'b0111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
